// File: rtl/greenhouse_pkg.sv
// Shared definitions for the greenhouse clock-setting path: time_adjust step codes,
// the button-lock FSM states and the press-priority helpers.
package greenhouse_pkg;

    localparam logic [2:0] ADJ_NONE      = 3'd0;
    localparam logic [2:0] ADJ_MIN_UP    = 3'd1;
    localparam logic [2:0] ADJ_MIN_DOWN  = 3'd2;
    localparam logic [2:0] ADJ_HOUR_UP   = 3'd3;
    localparam logic [2:0] ADJ_HOUR_DOWN = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } adj_state_t;

    // Button index order is min_up, min_down, hour_up, hour_down; lowest index wins.
    function automatic logic [1:0] press_winner(input logic [3:0] press);
        logic [1:0] idx;
        if (press[0])      idx = 2'd0;
        else if (press[1]) idx = 2'd1;
        else if (press[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

    function automatic logic [2:0] btn_code(input logic [1:0] idx);
        logic [2:0] code;
        case (idx)
            2'd0:    code = ADJ_MIN_UP;
            2'd1:    code = ADJ_MIN_DOWN;
            2'd2:    code = ADJ_HOUR_UP;
            default: code = ADJ_HOUR_DOWN;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counting debouncer: one raw asynchronous button in,
// one clean level out after DEBOUNCE_CYCLES consecutive disagreeing samples.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_adjust_ctrl.sv
// Front-panel button conditioner producing single-cycle time_adjust step codes.
// Define TIME_ADJUST_REPEAT_EN to build the hold-to-repeat timer.
module time_adjust_ctrl
    import greenhouse_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = CLK_HZ / 100,
    parameter int unsigned REPEAT_DELAY    = CLK_HZ / 2,
    parameter int unsigned REPEAT_PERIOD   = CLK_HZ / 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_min_up,
    input  logic       btn_min_down,
    input  logic       btn_hour_up,
    input  logic       btn_hour_down,
    output logic [2:0] time_adjust,
    output logic       adj_active
);

    localparam int unsigned CNT_MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > REPEAT_PERIOD) ? CNT_MAX_A : REPEAT_PERIOD;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX) + 1;

    logic [3:0] btn_raw;
    logic [3:0] level;
    logic [3:0] level_q;
    logic [3:0] press;
    logic [3:0] rel;
    logic [1:0] lock_idx;
    adj_state_t state;

    assign btn_raw = {btn_hour_down, btn_hour_up, btn_min_down, btn_min_up};
    assign press   = level & ~level_q;
    assign rel     = ~level & level_q;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn_raw[i]),
            .level  (level[i])
        );
    end

`ifdef TIME_ADJUST_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD);
    // Counts cycles since the last emitted pulse; loaded with 1 on each pulse.
    logic [CNT_W-1:0] rpt_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            level_q     <= '0;
            lock_idx    <= 2'd0;
            time_adjust <= ADJ_NONE;
            adj_active  <= 1'b0;
`ifdef TIME_ADJUST_REPEAT_EN
            rpt_cnt     <= '0;
`endif
        end else begin
            level_q     <= level;
            time_adjust <= ADJ_NONE;
            case (state)
                ST_IDLE: begin
                    if (|press) begin
                        lock_idx    <= press_winner(press);
                        time_adjust <= btn_code(press_winner(press));
                        adj_active  <= 1'b1;
                        state       <= ST_HOLD;
`ifdef TIME_ADJUST_REPEAT_EN
                        rpt_cnt     <= CNT_W'(1);
`endif
                    end
                end
                ST_HOLD: begin
                    if (rel[lock_idx]) begin
                        adj_active <= 1'b0;
                        state      <= ST_IDLE;
                    end
`ifdef TIME_ADJUST_REPEAT_EN
                    else if (rpt_cnt == DELAY_LAST) begin
                        time_adjust <= btn_code(lock_idx);
                        rpt_cnt     <= CNT_W'(1);
                        state       <= ST_REPEAT;
                    end else if (rpt_cnt != '1) begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
`endif
                end
`ifdef TIME_ADJUST_REPEAT_EN
                ST_REPEAT: begin
                    if (rel[lock_idx]) begin
                        adj_active <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (rpt_cnt == PERIOD_LAST) begin
                        time_adjust <= btn_code(lock_idx);
                        rpt_cnt     <= CNT_W'(1);
                    end else if (rpt_cnt != '1) begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    adj_active <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Self-checking bench for time_adjust_ctrl: table vectors, corner sequences and random
// button activity compared cycle by cycle against a behavioural model.
module tb_time_adjust_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef TIME_ADJUST_REPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic [2:0] time_adjust;
    logic       adj_active;

    always #5 clk = ~clk;

    time_adjust_ctrl #(
        .CLK_HZ         (1000),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_min_up   (btn[0]),
        .btn_min_down (btn[1]),
        .btn_hour_up  (btn[2]),
        .btn_hour_down(btn[3]),
        .time_adjust  (time_adjust),
        .adj_active   (adj_active)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: raw-sample history per button, debounced levels, and the lock/pulse schedule.
    logic [DB:0] m_hist [4];
    logic [3:0]  m_lvl;
    logic [3:0]  m_lvlq;
    bit          m_locked;
    int          m_lock;
    int          m_t0;
    logic [2:0]  exp_code;
    logic        exp_active;

    int obs [8];
    int first_pulse;

    typedef struct {
        logic [3:0] mask;
        int         hold;
        int         pulses;
        logic [2:0] code;
    } vec_t;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < 4; b++) m_hist[b] = '0;
        m_lvl      = '0;
        m_lvlq     = '0;
        m_locked   = 1'b0;
        m_lock     = 0;
        m_t0       = 0;
        exp_code   = 3'd0;
        exp_active = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] press;
        logic [3:0] rel;
        int         win;
        int         k;
        bit         all_diff;
        cyc++;
        if (!rst_n) begin
            model_clear();
            return;
        end
        press    = m_lvl & ~m_lvlq;
        rel      = ~m_lvl & m_lvlq;
        exp_code = 3'd0;
        if (!m_locked) begin
            if (press != 4'd0) begin
                win = 3;
                for (int b = 3; b >= 0; b--) if (press[b]) win = b;
                m_locked = 1'b1;
                m_lock   = win;
                m_t0     = cyc;
                exp_code = 3'(win + 1);
            end
        end else if (rel[m_lock]) begin
            m_locked = 1'b0;
        end else begin
            k = cyc - m_t0;
            if (RPT && k >= RD && ((k - RD) % RP) == 0) exp_code = 3'(m_lock + 1);
        end
        exp_active = m_locked;
        m_lvlq = m_lvl;
        // A level flips once the last DB synchronised samples all disagree with it.
        for (int b = 0; b < 4; b++) begin
            all_diff = 1'b1;
            for (int i = 1; i <= DB; i++) if (m_hist[b][i] == m_lvl[b]) all_diff = 1'b0;
            if (all_diff) m_lvl[b] = ~m_lvl[b];
            m_hist[b] = {m_hist[b][DB-1:0], btn[b]};
        end
    endtask

    task automatic obs_clear();
        for (int i = 0; i < 8; i++) obs[i] = 0;
        first_pulse = -1;
    endtask

    function automatic int obs_total();
        int t = 0;
        for (int i = 1; i < 8; i++) t += obs[i];
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("time_adjust", 32'(time_adjust), 32'(exp_code));
        check_eq("adj_active", 32'(adj_active), 32'(exp_active));
        if (time_adjust != 3'd0) begin
            obs[time_adjust]++;
            if (first_pulse < 0) first_pulse = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        vec_t vecs [10];
        int   start;

        // Reset held with every button pressed.
        rst_n = 1'b0;
        btn   = 4'hF;
        model_clear();
        obs_clear();
        run(5);
        check_eq("reset_time_adjust", 32'(time_adjust), 32'd0);
        check_eq("reset_adj_active", 32'(adj_active), 32'd0);
        btn = 4'h0;
        run(2);
        rst_n = 1'b1;
        run(3);

        vecs[0] = '{4'b0001, 10, 1, 3'd1};
        vecs[1] = '{4'b1000, 60, RPT ? 6 : 1, 3'd4};
        vecs[2] = '{4'b0110, 10, 1, 3'd2};
        vecs[3] = '{4'b0001, 3, 0, 3'd1};
        vecs[4] = '{4'b0001, 4, 1, 3'd1};
        vecs[5] = '{4'b0100, 20, 1, 3'd3};
        vecs[6] = '{4'b0100, 21, RPT ? 2 : 1, 3'd3};
        vecs[7] = '{4'b1000, 29, RPT ? 3 : 1, 3'd4};
        vecs[8] = '{4'b0011, 8, 1, 3'd1};
        vecs[9] = '{4'b1100, 8, 1, 3'd3};

        for (int v = 0; v < 10; v++) begin
            obs_clear();
            start = cyc;
            btn   = vecs[v].mask;
            run(vecs[v].hold);
            btn = 4'h0;
            run(14);
            check_eq($sformatf("vec%0d_count", v), 32'(obs_total()), 32'(vecs[v].pulses));
            check_eq($sformatf("vec%0d_code", v), 32'(obs[vecs[v].code]), 32'(vecs[v].pulses));
            if (vecs[v].pulses != 0)
                check_eq($sformatf("vec%0d_latency", v), 32'(first_pulse - start), 32'd7);
            check_eq($sformatf("vec%0d_idle", v), 32'(adj_active), 32'd0);
        end

        // Bouncing min_down that never settles high.
        obs_clear();
        for (int r = 0; r < 5; r++) begin
            btn[1] = 1'b1; run(2);
            btn[1] = 1'b0; run(1);
        end
        run(14);
        check_eq("bounce_only_count", 32'(obs_total()), 32'd0);

        // Same bounce, then a stable press.
        obs_clear();
        for (int r = 0; r < 5; r++) begin
            btn[1] = 1'b1; run(2);
            btn[1] = 1'b0; run(1);
        end
        btn[1] = 1'b1;
        run(15);
        btn = 4'h0;
        run(14);
        check_eq("bounce_settle_code2", 32'(obs[2]), 32'd1);
        check_eq("bounce_settle_count", 32'(obs_total()), 32'd1);

        // Simultaneous press, then another button pressed while locked.
        obs_clear();
        btn = 4'b0110;
        run(8);
        btn[0] = 1'b1;
        run(10);
        btn = 4'h0;
        run(14);
        check_eq("lock_code2", 32'(obs[2]), 32'd1);
        check_eq("lock_code1_ignored", 32'(obs[1]), 32'd0);
        check_eq("lock_code3_ignored", 32'(obs[3]), 32'd0);
        obs_clear();
        btn = 4'b0100;
        run(10);
        btn = 4'h0;
        run(14);
        check_eq("after_lock_code3", 32'(obs[3]), 32'd1);
        check_eq("after_lock_count", 32'(obs_total()), 32'd1);

        // Reset pulsed mid-hold with the button kept down.
        obs_clear();
        btn = 4'b0001;
        run(15);
        check_eq("prerst_code1", 32'(obs[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_active", 32'(adj_active), 32'd0);
        check_eq("rst_async_code", 32'(time_adjust), 32'd0);
        run(3);
        rst_n = 1'b1;
        obs_clear();
        start = cyc;
        run(15);
        btn = 4'h0;
        run(14);
        check_eq("postrst_code1", 32'(obs[1]), 32'd1);
        check_eq("postrst_count", 32'(obs_total()), 32'd1);
        check_eq("postrst_latency", 32'(first_pulse - start), 32'd7);

        // Random button activity against the model.
        for (int s = 0; s < 250; s++) begin
            btn = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) btn = 4'h0;
            if ($urandom_range(0, 60) == 0) begin
                rst_n = 1'b0;
                run(2);
                rst_n = 1'b1;
            end
            run(int'($urandom_range(1, 30)));
        end
        btn = 4'h0;
        run(20);
        check_eq("final_idle", 32'(adj_active), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
